// File: rtl/cvw_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cvw_pkg                                                      |
// | Description : Shared types and defaults for the Ethernet TX arbiter:       |
// |               arbiter state encoding, default starvation limit and         |
// |               inter-frame-gap length, counter widths.                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package cvw_pkg;

    // Arbiter states. SEND0/SEND1 own the MAC stream; GAP enforces the IFG.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND0 = 2'd1,
        ST_SEND1 = 2'd2,
        ST_GAP   = 2'd3
    } arb_state_t;

    localparam int DEF_STARVE_LIMIT = 4;
    localparam int DEF_IFG_CYCLES   = 2;

    // IFG_CYCLES ranges 0..255, so an 8-bit gap counter is always enough.
    localparam int GAP_CNT_W   = 8;
    localparam int FRAME_CNT_W = 16;

endpackage
`default_nettype wire

// File: rtl/framecounter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : framecounter                                                 |
// | Description : 16-bit wrapping event counter with enable and asynchronous   |
// |               active-low clear.                                            |
// | Ports       : clk     - clock                                              |
// |               clrn_i  - asynchronous clear, active low                     |
// |               en_i    - count enable, +1 per rising edge while high        |
// |               count_o - current count (wraps 0xFFFF -> 0x0000)             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module framecounter
    import cvw_pkg::*;
(
    input  logic                   clk,
    input  logic                   clrn_i,
    input  logic                   en_i,
    output logic [FRAME_CNT_W-1:0] count_o
);

    logic [FRAME_CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge clrn_i) begin
        if (!clrn_i) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/eth_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : eth_tx_arbiter                                               |
// | Description : Two-input frame arbiter in front of the Ethernet MAC TX      |
// |               stream. Port 1 (control frames) normally wins; port 0        |
// |               (RVVI frames) is forced through after STARVE_LIMIT           |
// |               consecutive port-1 grants while it was waiting. Frames are   |
// |               never interleaved and IFG_CYCLES idle cycles follow each.    |
// | Ports       : clk, resetn          - clock, async active-low reset         |
// |               Enable               - permits new grants                    |
// |               S0T*/S0Tready        - RVVI packetizer stream in             |
// |               S1T*/S1Tready        - control frame stream in               |
// |               MT*/MTready          - stream out to the MAC                 |
// |               Busy                 - sending or in the inter-frame gap     |
// |               FrameCount0/1        - completed frames per port             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module eth_tx_arbiter
    import cvw_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int KEEP_WIDTH   = DATA_WIDTH / 8,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
    parameter int IFG_CYCLES   = DEF_IFG_CYCLES
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   Enable,

    input  logic [DATA_WIDTH-1:0]  S0Tdata,
    input  logic [KEEP_WIDTH-1:0]  S0Tkeep,
    input  logic                   S0Tvalid,
    input  logic                   S0Tlast,
    output logic                   S0Tready,

    input  logic [DATA_WIDTH-1:0]  S1Tdata,
    input  logic [KEEP_WIDTH-1:0]  S1Tkeep,
    input  logic                   S1Tvalid,
    input  logic                   S1Tlast,
    output logic                   S1Tready,

    output logic [DATA_WIDTH-1:0]  MTdata,
    output logic [KEEP_WIDTH-1:0]  MTkeep,
    output logic                   MTvalid,
    output logic                   MTlast,
    input  logic                   MTready,

    output logic                   Busy,
    output logic [FRAME_CNT_W-1:0] FrameCount0,
    output logic [FRAME_CNT_W-1:0] FrameCount1
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0]        STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [GAP_CNT_W-1:0] GAP_LOAD   = GAP_CNT_W'(IFG_CYCLES - 1);

    arb_state_t           state_q, state_d;
    logic [SW-1:0]        starve_q, starve_d;
    logic [GAP_CNT_W-1:0] gap_q, gap_d;
    // Low for the first rising edge after reset release, so the earliest
    // grant lands on the second edge.
    logic                 armed_q;
    logic                 fc0_en, fc1_en;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            starve_q <= '0;
            gap_q    <= '0;
            armed_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            gap_q    <= gap_d;
            armed_q  <= 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        gap_d    = gap_q;
        fc0_en   = 1'b0;
        fc1_en   = 1'b0;
        MTdata   = '0;
        MTkeep   = '0;
        MTvalid  = 1'b0;
        MTlast   = 1'b0;
        S0Tready = 1'b0;
        S1Tready = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (armed_q && Enable && (S0Tvalid || S1Tvalid)) begin
                    if (S1Tvalid && !(S0Tvalid && (starve_q == STARVE_MAX))) begin
                        state_d = ST_SEND1;
                        // Only grants that bypass a waiting port 0 count
                        // towards starvation.
                        if (S0Tvalid) begin
                            starve_d = (starve_q == STARVE_MAX) ? starve_q
                                                                : starve_q + 1'b1;
                        end else begin
                            starve_d = '0;
                        end
                    end else begin
                        state_d  = ST_SEND0;
                        starve_d = '0;
                    end
                end
            end

            ST_SEND0: begin
                MTdata   = S0Tdata;
                MTkeep   = S0Tkeep;
                MTvalid  = S0Tvalid;
                MTlast   = S0Tlast;
                S0Tready = MTready;
                if (S0Tvalid && MTready && S0Tlast) begin
                    fc0_en = 1'b1;
                    if (IFG_CYCLES == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_GAP;
                        gap_d   = GAP_LOAD;
                    end
                end
            end

            ST_SEND1: begin
                MTdata   = S1Tdata;
                MTkeep   = S1Tkeep;
                MTvalid  = S1Tvalid;
                MTlast   = S1Tlast;
                S1Tready = MTready;
                if (S1Tvalid && MTready && S1Tlast) begin
                    fc1_en = 1'b1;
                    if (IFG_CYCLES == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_GAP;
                        gap_d   = GAP_LOAD;
                    end
                end
            end

            ST_GAP: begin
                // Loaded with IFG_CYCLES-1, so exit on zero gives exactly
                // IFG_CYCLES cycles here.
                if (gap_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign Busy = (state_q != ST_IDLE);

    framecounter u_fc0 (
        .clk     (clk),
        .clrn_i  (resetn),
        .en_i    (fc0_en),
        .count_o (FrameCount0)
    );

    framecounter u_fc1 (
        .clk     (clk),
        .clrn_i  (resetn),
        .en_i    (fc1_en),
        .count_o (FrameCount1)
    );

endmodule
`default_nettype wire

// File: tb/tb_eth_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_eth_tx_arbiter                                            |
// | Description : Self-checking bench for eth_tx_arbiter: frame-level          |
// |               reference model compared every cycle, plus directed          |
// |               scenarios with literal expectations.                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_eth_tx_arbiter;

    localparam int DW  = 32;
    localparam int KW  = 4;
    localparam int SL  = 4;
    localparam int IFG = 2;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          Enable = 1'b0;
    logic [DW-1:0] S0Tdata = '0, S1Tdata = '0;
    logic [KW-1:0] S0Tkeep = '0, S1Tkeep = '0;
    logic          S0Tvalid = 1'b0, S0Tlast = 1'b0, S1Tvalid = 1'b0, S1Tlast = 1'b0;
    logic          S0Tready, S1Tready;
    logic [DW-1:0] MTdata;
    logic [KW-1:0] MTkeep;
    logic          MTvalid, MTlast;
    logic          MTready = 1'b0;
    logic          Busy;
    logic [15:0]   FrameCount0, FrameCount1;

    logic          fc_clrn = 1'b0;
    logic          fc_en = 1'b0;
    logic [15:0]   fc_cnt;

    always #5 clk = ~clk;

    eth_tx_arbiter #(
        .DATA_WIDTH   (DW),
        .KEEP_WIDTH   (KW),
        .STARVE_LIMIT (SL),
        .IFG_CYCLES   (IFG)
    ) dut (
        .clk (clk), .resetn (resetn), .Enable (Enable),
        .S0Tdata (S0Tdata), .S0Tkeep (S0Tkeep), .S0Tvalid (S0Tvalid),
        .S0Tlast (S0Tlast), .S0Tready (S0Tready),
        .S1Tdata (S1Tdata), .S1Tkeep (S1Tkeep), .S1Tvalid (S1Tvalid),
        .S1Tlast (S1Tlast), .S1Tready (S1Tready),
        .MTdata (MTdata), .MTkeep (MTkeep), .MTvalid (MTvalid),
        .MTlast (MTlast), .MTready (MTready),
        .Busy (Busy), .FrameCount0 (FrameCount0), .FrameCount1 (FrameCount1)
    );

    // Standalone counter so the 16-bit wrap can be reached in ~64k cycles.
    framecounter u_fc (
        .clk (clk), .clrn_i (fc_clrn), .en_i (fc_en), .count_o (fc_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s timed out at %0t", nm, $time);
    endtask

    // ---------------- reference model (frame level) ----------------
    // m_owner: port currently streaming (-1 none); m_gap: idle cycles still
    // owed after the last frame; m_armed: one edge has passed since reset.
    int m_owner = -1;
    int m_gap = 0;
    int m_starve = 0;
    bit m_armed = 1'b0;
    int m_fc[2] = '{0, 0};
    int m_q[$];

    always @(negedge resetn) begin
        m_owner  = -1;
        m_gap    = 0;
        m_starve = 0;
        m_armed  = 1'b0;
        m_fc     = '{0, 0};
    end

    always @(posedge clk) begin
        if (resetn) begin
            if (m_owner >= 0) begin
                if ((m_owner == 0 ? (S0Tvalid && S0Tlast) : (S1Tvalid && S1Tlast)) && MTready) begin
                    m_fc[m_owner] = (m_fc[m_owner] + 1) % 65536;
                    m_owner = -1;
                    m_gap   = IFG;
                end
            end else if (m_gap > 0) begin
                m_gap = m_gap - 1;
            end else if (m_armed && Enable && (S0Tvalid || S1Tvalid)) begin
                if (S1Tvalid && !(S0Tvalid && m_starve == SL)) begin
                    m_owner  = 1;
                    m_starve = S0Tvalid ? ((m_starve < SL) ? m_starve + 1 : SL) : 0;
                end else begin
                    m_owner  = 0;
                    m_starve = 0;
                end
                m_q.push_back(m_owner);
            end
            m_armed = 1'b1;
        end
    end

    // ---------------- per-cycle compare ----------------
    int  busy_total = 0;
    int  mtlast_total = 0;
    bit  busy_prev = 1'b0;
    int  dut_q[$];

    always @(negedge clk) begin
        logic [DW-1:0] e_d;
        logic [KW-1:0] e_k;
        logic e_v, e_l, e_r0, e_r1, e_busy;
        if (resetn) begin
            e_d = '0; e_k = '0; e_v = 1'b0; e_l = 1'b0; e_r0 = 1'b0; e_r1 = 1'b0;
            if (m_owner == 0) begin
                e_d = S0Tdata; e_k = S0Tkeep; e_v = S0Tvalid; e_l = S0Tlast; e_r0 = MTready;
            end else if (m_owner == 1) begin
                e_d = S1Tdata; e_k = S1Tkeep; e_v = S1Tvalid; e_l = S1Tlast; e_r1 = MTready;
            end
            e_busy = (m_owner >= 0) || (m_gap > 0);
            chk("mdl_MTvalid", MTvalid, e_v);
            chk("mdl_MTdata", MTdata, e_d);
            chk("mdl_MTkeep", MTkeep, e_k);
            chk("mdl_MTlast", MTlast, e_l);
            chk("mdl_S0Tready", S0Tready, e_r0);
            chk("mdl_S1Tready", S1Tready, e_r1);
            chk("mdl_Busy", Busy, e_busy);
            chk("mdl_FrameCount0", FrameCount0, m_fc[0]);
            chk("mdl_FrameCount1", FrameCount1, m_fc[1]);
            if (Busy) busy_total++;
            if (MTlast) mtlast_total++;
            if (Busy && !busy_prev) dut_q.push_back(S1Tready ? 1 : (S0Tready ? 0 : 9));
            busy_prev = Busy;
        end else begin
            busy_prev = 1'b0;
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [DW-1:0] bdat(input int p, input int f, input int b);
        return 32'hA000_0000 | DW'(p << 20) | DW'(f << 8) | DW'(b);
    endfunction

    task automatic drive_port(input int p, input logic v, input logic [DW-1:0] d,
                              input logic [KW-1:0] k, input logic l);
        if (p == 0) begin
            S0Tvalid = v; S0Tdata = d; S0Tkeep = k; S0Tlast = l;
        end else begin
            S1Tvalid = v; S1Tdata = d; S1Tkeep = k; S1Tlast = l;
        end
    endtask

    // Sends one frame, holding each beat until the handshake edge.
    task automatic src(input int p, input int nb, input int f);
        bit hs;
        int n;
        for (int b = 0; b < nb; b++) begin
            drive_port(p, 1'b1, bdat(p, f, b), (b == nb - 1) ? 4'h3 : 4'hF, b == nb - 1);
            hs = 1'b0;
            n  = 0;
            while (!hs && n < 200) begin
                @(negedge clk);
                hs = (p == 0) ? S0Tready : S1Tready;
                @(posedge clk);
                n++;
            end
            if (!hs) timeout_fail("src_handshake");
            #1;
        end
        drive_port(p, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic reset_dut();
        resetn = 1'b0;
        drive_port(0, 1'b0, '0, '0, 1'b0);
        drive_port(1, 1'b0, '0, '0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int dq0, mq0, b0, l0, n;
        logic [7:0] ev, eb;
        logic [DW-1:0] edat;
        int ord033[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        bit done;

        // Outputs while reset is held.
        #2;
        chk("rst_MTvalid", MTvalid, 1'b0);
        chk("rst_Busy", Busy, 1'b0);
        chk("rst_S0Tready", S0Tready, 1'b0);
        chk("rst_FC0", FrameCount0, 16'h0);
        chk("rst_FC1", FrameCount1, 16'h0);
        reset_dut();

        // Lone 3-beat S0 frame: beats in cycles 1..3, GAP 4..5, IDLE from 6.
        MTready = 1'b1;
        Enable  = 1'b1;
        b0 = busy_total;
        ev = 8'b0000_1110;
        eb = 8'b0011_1110;
        for (int c = 0; c < 8; c++) begin
            case (c)
                0, 1:    drive_port(0, 1'b1, bdat(0, 0, 0), 4'hF, 1'b0);
                2:       drive_port(0, 1'b1, bdat(0, 0, 1), 4'hF, 1'b0);
                3:       drive_port(0, 1'b1, bdat(0, 0, 2), 4'h3, 1'b1);
                default: drive_port(0, 1'b0, '0, '0, 1'b0);
            endcase
            edat = (c >= 1 && c <= 3) ? bdat(0, 0, c - 1) : '0;
            @(negedge clk);
            chk("t1_MTvalid", MTvalid, ev[c]);
            chk("t1_Busy", Busy, eb[c]);
            chk("t1_MTdata", MTdata, edat);
            @(posedge clk);
            #1;
        end
        chk("t1_busy_cycles", busy_total - b0, 5);
        chk("t1_FC0", FrameCount0, 16'd1);
        chk("t1_FC1", FrameCount1, 16'd0);

        // Both ports continuously valid: starvation relief every fifth grant.
        reset_dut();
        MTready = 1'b1;
        Enable  = 1'b1;
        dq0 = dut_q.size();
        mq0 = m_q.size();
        fork
            begin
                for (int f = 0; f < 2; f++) src(0, 3, f);
            end
            begin
                for (int f = 0; f < 8; f++) src(1, 2, f);
            end
        join
        idle_cycles(4);
        chk("t2_dut_grants", dut_q.size() - dq0, 10);
        chk("t2_mdl_grants", m_q.size() - mq0, 10);
        for (int i = 0; i < 10; i++) begin
            if (dq0 + i < dut_q.size()) chk("t2_dut_order", dut_q[dq0 + i], ord033[i]);
            if (mq0 + i < m_q.size())   chk("t2_mdl_order", m_q[mq0 + i], ord033[i]);
        end
        chk("t2_FC1", FrameCount1, 16'd8);
        chk("t2_FC0", FrameCount0, 16'd2);

        // S1 frame under MTready toggling 1,0; S0 rises the same cycle and waits.
        reset_dut();
        MTready = 1'b1;
        Enable  = 1'b1;
        mq0  = m_q.size();
        done = 1'b0;
        fork
            begin
                src(1, 3, 0);
                done = 1'b1;
            end
            src(0, 1, 0);
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    MTready = ~MTready;
                end
                MTready = 1'b1;
            end
        join
        idle_cycles(4);
        chk("t3_mdl_grants", m_q.size() - mq0, 2);
        if (m_q.size() >= mq0 + 2) begin
            chk("t3_first", m_q[mq0], 1);
            chk("t3_second", m_q[mq0 + 1], 0);
        end
        chk("t3_FC1", FrameCount1, 16'd1);
        chk("t3_FC0", FrameCount0, 16'd1);

        // Enable dropped during beat 2 of a 4-beat S0 frame with S1 pending.
        reset_dut();
        MTready = 1'b1;
        Enable  = 1'b1;
        fork
            src(0, 4, 0);
            begin
                repeat (2) @(posedge clk);
                #1;
                Enable = 1'b0;
                drive_port(1, 1'b1, bdat(1, 0, 0), 4'hF, 1'b1);
            end
        join
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t4_hold_S1Tready", S1Tready, 1'b0);
            chk("t4_hold_MTvalid", MTvalid, 1'b0);
        end
        chk("t4_FC0", FrameCount0, 16'd1);
        chk("t4_idle_Busy", Busy, 1'b0);
        @(posedge clk);
        #1;
        Enable = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!S1Tready && n < 20);
        if (!S1Tready) timeout_fail("t4_S1_grant");
        @(posedge clk);
        #1;
        drive_port(1, 1'b0, '0, '0, 1'b0);
        idle_cycles(4);
        chk("t4_FC1", FrameCount1, 16'd1);

        // Reset pulse during beat 2 abandons the frame; re-arm takes two edges.
        reset_dut();
        MTready = 1'b1;
        Enable  = 1'b1;
        l0 = mtlast_total;
        drive_port(0, 1'b1, bdat(0, 0, 0), 4'hF, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        drive_port(0, 1'b1, bdat(0, 0, 1), 4'hF, 1'b0);
        #1;
        chk("t5_beat2_MTvalid", MTvalid, 1'b1);
        resetn = 1'b0;
        drive_port(0, 1'b0, '0, '0, 1'b0);
        #1;
        chk("t5_rst_MTvalid", MTvalid, 1'b0);
        chk("t5_rst_Busy", Busy, 1'b0);
        chk("t5_rst_FC0", FrameCount0, 16'd0);
        chk("t5_rst_S0Tready", S0Tready, 1'b0);
        @(posedge clk);
        #3;
        resetn = 1'b1;
        drive_port(0, 1'b1, bdat(0, 1, 0), 4'h3, 1'b1);
        @(negedge clk);
        chk("t5_pre_MTvalid", MTvalid, 1'b0);
        @(negedge clk);
        chk("t5_arm_MTvalid", MTvalid, 1'b0);
        chk("t5_no_MTlast", mtlast_total - l0, 0);
        @(negedge clk);
        chk("t5_grant_MTvalid", MTvalid, 1'b1);
        chk("t5_grant_MTlast", MTlast, 1'b1);
        @(posedge clk);
        #1;
        drive_port(0, 1'b0, '0, '0, 1'b0);
        idle_cycles(4);
        chk("t5_FC0", FrameCount0, 16'd1);

        // 16-bit frame counter wrap.
        fc_clrn = 1'b0;
        @(posedge clk);
        #1;
        fc_clrn = 1'b1;
        chk("t6_clear", fc_cnt, 16'h0000);
        fc_en = 1'b1;
        repeat (65535) @(posedge clk);
        #1;
        fc_en = 1'b0;
        chk("t6_full", fc_cnt, 16'hFFFF);
        @(posedge clk);
        #1;
        chk("t6_hold", fc_cnt, 16'hFFFF);
        fc_en = 1'b1;
        @(posedge clk);
        #1;
        fc_en = 1'b0;
        chk("t6_wrap", fc_cnt, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
